// File: rtl/gram_arbiter.sv
// Two-port round-robin arbiter that serializes a granted 16-bit byte address
// into the RAM's hi/lo address pipeline, performs the access and acknowledges.
module gram_arbiter #(
  parameter logic [15:0] GRAM_START_ADDRESS = 16'h0000,
  parameter logic [15:0] BANK_SIZE          = 16'h0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        b_err,
  output logic [7:0]  ram_rd_addr,
  output logic [7:0]  ram_wr_addr,
  output logic        ram_wr_en,
  output logic [7:0]  ram_wr_data,
  input  logic [7:0]  ram_rd_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    XFER = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        grant_r, grant_s;          // 0 = port A, 1 = port B
  logic        last_grant_r, last_grant_s;
  logic        we_r, we_s;
  logic        rej_r, rej_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;

  logic        sel_b_s;
  logic        req_we_s;
  logic [15:0] req_addr_s;
  logic [7:0]  req_wdata_s;
  logic [16:0] offset_s;
  logic        in_win_s;

  logic [7:0]  ram_addr_s;
  logic        ram_wr_en_s;
  logic [7:0]  ram_wr_data_s;
  logic        a_ack_s, b_ack_s, a_err_s, b_err_s;
  logic [7:0]  a_rdata_s, b_rdata_s;

  // Candidate selection (round-robin on a tie) and 17-bit window check
  always_comb begin
    if (a_req && b_req) begin
      sel_b_s = ~last_grant_r;
    end else if (b_req) begin
      sel_b_s = 1'b1;
    end else begin
      sel_b_s = 1'b0;
    end
    req_we_s    = sel_b_s ? b_we    : a_we;
    req_addr_s  = sel_b_s ? b_addr  : a_addr;
    req_wdata_s = sel_b_s ? b_wdata : a_wdata;
    // Addresses below the window start wrap to a large 17-bit offset.
    offset_s    = {1'b0, req_addr_s} - {1'b0, GRAM_START_ADDRESS};
    in_win_s    = offset_s < {1'b0, BANK_SIZE};
  end

  // Next-state logic and transaction capture
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    we_s         = we_r;
    rej_s        = rej_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    case (state_r)
      IDLE: begin
        if (a_req || b_req) begin
          grant_s      = sel_b_s;
          last_grant_s = sel_b_s;
          we_s         = req_we_s;
          addr_s       = req_addr_s;
          wdata_s      = req_wdata_s;
          rej_s        = ~in_win_s;
          state_s      = in_win_s ? HI : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      HI:      state_s = LO;
      LO:      state_s = XFER;
      XFER:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    ram_addr_s    = 8'h00;
    ram_wr_en_s   = 1'b0;
    ram_wr_data_s = 8'h00;
    case (state_s)
      HI:   ram_addr_s = addr_s[15:8];
      LO:   ram_addr_s = addr_s[7:0];
      XFER: begin
        ram_wr_en_s   = we_s;
        ram_wr_data_s = wdata_s;
      end
      default: ram_addr_s = 8'h00;
    endcase
    a_ack_s = (state_s == RESP) && !grant_s;
    b_ack_s = (state_s == RESP) && grant_s;
    a_err_s = a_ack_s && rej_s;
    b_err_s = b_ack_s && rej_s;
    a_rdata_s = a_rdata;
    b_rdata_s = b_rdata;
    if ((state_r == XFER) && !we_r) begin
      if (grant_r) begin
        b_rdata_s = ram_rd_data;
      end else begin
        a_rdata_s = ram_rd_data;
      end
    end else if ((state_r == IDLE) && (state_s == RESP)) begin
      if (grant_s) begin
        b_rdata_s = 8'hFF;
      end else begin
        a_rdata_s = 8'hFF;
      end
    end else begin
      a_rdata_s = a_rdata;
      b_rdata_s = b_rdata;
    end
  end

  // State, captured transaction and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      rej_r        <= 1'b0;
      addr_r       <= 16'h0000;
      wdata_r      <= 8'h00;
      ram_rd_addr  <= 8'h00;
      ram_wr_addr  <= 8'h00;
      ram_wr_en    <= 1'b0;
      ram_wr_data  <= 8'h00;
      a_ack        <= 1'b0;
      a_err        <= 1'b0;
      a_rdata      <= 8'h00;
      b_ack        <= 1'b0;
      b_err        <= 1'b0;
      b_rdata      <= 8'h00;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      we_r         <= we_s;
      rej_r        <= rej_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      ram_rd_addr  <= ram_addr_s;
      ram_wr_addr  <= ram_addr_s;
      ram_wr_en    <= ram_wr_en_s;
      ram_wr_data  <= ram_wr_data_s;
      a_ack        <= a_ack_s;
      a_err        <= a_err_s;
      a_rdata      <= a_rdata_s;
      b_ack        <= b_ack_s;
      b_err        <= b_err_s;
      b_rdata      <= b_rdata_s;
    end
  end

endmodule

// File: tb/tb_gram_arbiter.sv
// Scoreboard bench for gram_arbiter: two DUTs (default window and a window at
// 16'hC000), each with a behavioural RAM that registers its hi/lo address bytes.
module tb_gram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = 16'h0000, b_addr = 16'h0000;
  logic [7:0]  a_wdata = 8'h00, b_wdata = 8'h00;
  logic        a_ack, a_err, b_ack, b_err;
  logic [7:0]  a_rdata, b_rdata;
  logic [7:0]  r0_rd_addr, r0_wr_addr, r0_wr_data, r0_rd_data;
  logic        r0_wr_en;

  logic        c_req = 1'b0, c_we = 1'b0;
  logic [15:0] c_addr = 16'h0000;
  logic [7:0]  c_wdata = 8'h00;
  logic        c_ack, c_err, d_ack, d_err;
  logic [7:0]  c_rdata, d_rdata;
  logic [7:0]  r1_rd_addr, r1_wr_addr, r1_wr_data, r1_rd_data;
  logic        r1_wr_en;

  gram_arbiter dut0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .ram_rd_addr(r0_rd_addr), .ram_wr_addr(r0_wr_addr), .ram_wr_en(r0_wr_en),
    .ram_wr_data(r0_wr_data), .ram_rd_data(r0_rd_data)
  );

  gram_arbiter #(.GRAM_START_ADDRESS(16'hC000), .BANK_SIZE(16'h0400)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
    .a_ack(c_ack), .a_rdata(c_rdata), .a_err(c_err),
    .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0000), .b_wdata(8'h00),
    .b_ack(d_ack), .b_rdata(d_rdata), .b_err(d_err),
    .ram_rd_addr(r1_rd_addr), .ram_wr_addr(r1_wr_addr), .ram_wr_en(r1_wr_en),
    .ram_wr_data(r1_wr_data), .ram_rd_data(r1_rd_data)
  );

  // Behavioural RAMs: address bytes shift through a two-stage register
  logic [7:0] ram0 [0:1023];
  logic [7:0] ram1 [0:1023];
  logic [7:0] r0_rh, r0_rl, r0_wh, r0_wl, r1_rh, r1_rl, r1_wh, r1_wl;
  bit ram_ready = 1'b0;
  wire [15:0] r0_rword = {r0_rh, r0_rl};
  wire [15:0] r0_wword = {r0_wh, r0_wl};
  wire [15:0] r1_rword = {r1_rh, r1_rl};
  wire [15:0] r1_wword = {r1_wh, r1_wl};
  assign r0_rd_data = ram0[r0_rword[9:0]];
  assign r1_rd_data = ram1[r1_rword[9:0]];

  always @(posedge clk) begin
    r0_rh <= r0_rl; r0_rl <= r0_rd_addr; r0_wh <= r0_wl; r0_wl <= r0_wr_addr;
    r1_rh <= r1_rl; r1_rl <= r1_rd_addr; r1_wh <= r1_wl; r1_wl <= r1_wr_addr;
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) begin
        ram0[i] <= 8'(i) ^ 8'hA5;
        ram1[i] <= 8'(i) ^ 8'h3C;
      end
      ram_ready <= 1'b1;
    end else begin
      if (r0_wr_en) ram0[r0_wword[9:0]] <= r0_wr_data;
      if (r1_wr_en) ram1[r1_wword[9:0]] <= r1_wr_data;
    end
  end

  // Reference model and scoreboard state
  logic [7:0] m0 [0:1023];
  logic [7:0] m1 [0:1023];
  logic [7:0] last_rd [0:2];
  logic [8:0] qa[$], qb[$], qc[$];
  int         ack_order[$];
  logic [8:0] mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] tr_rd [16];
  logic [7:0] tr_wr [16];
  logic [7:0] tr_wd [16];
  logic       tr_en [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected response from the port's window rules; p=2 is dut1 port A
  task automatic model_push(input int p, input bit we, input logic [15:0] addr, input logic [7:0] wd);
    int start;
    int off;
    logic [8:0] e;
    start = (p == 2) ? 32'hC000 : 0;
    off = int'(addr) - start;
    if (off < 0 || off >= 1024) begin
      e = {1'b1, 8'hFF};
      last_rd[p] = 8'hFF;
    end else if (we) begin
      if (p == 2) m1[off] = wd; else m0[off] = wd;
      e = {1'b0, last_rd[p]};
    end else begin
      e = {1'b0, (p == 2) ? m1[off] : m0[off]};
      last_rd[p] = e[7:0];
    end
    case (p)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic drive(input int p, input bit req, input bit we, input logic [15:0] addr, input logic [7:0] wd);
    case (p)
      0: begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
      1: begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
      default: begin c_req = req; c_we = we; c_addr = addr; c_wdata = wd; end
    endcase
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0: return a_ack;
      1: return b_ack;
      default: return c_ack;
    endcase
  endfunction

  task automatic sample_trace(input int p, input int c);
    if (c < 16) begin
      tr_rd[c] = (p == 2) ? r1_rd_addr : r0_rd_addr;
      tr_wr[c] = (p == 2) ? r1_wr_addr : r0_wr_addr;
      tr_wd[c] = (p == 2) ? r1_wr_data : r0_wr_data;
      tr_en[c] = (p == 2) ? r1_wr_en   : r0_wr_en;
    end
  endtask

  // Issue one request (called #1 after a rising edge) and wait for its ack
  task automatic txn(input int p, input bit we, input logic [15:0] addr, input logic [7:0] wd, output int ack_cyc);
    model_push(p, we, addr, wd);
    drive(p, 1'b1, we, addr, wd);
    ack_cyc = -1;
    sample_trace(p, 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      sample_trace(p, c);
      if (ack_of(p)) begin
        ack_cyc = c;
        break;
      end
    end
    drive(p, 1'b0, we, addr, wd);
    chk($sformatf("p%0d_ack_seen", p), 32'(ack_cyc >= 0), 32'd1);
  endtask

  task automatic rand_driver(input int p, input int n, input int max_gap);
    int dummy, gap;
    logic [15:0] addr;
    bit we;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) addr = 16'($urandom_range(32'h0400, 32'hFFFF));
      else if (p == 0) addr = 16'h0100 + 16'($urandom_range(0, 15));
      else addr = 16'h0300 + 16'($urandom_range(0, 15));
      txn(p, we, addr, 8'($urandom), dummy);
    end
  endtask

  // Monitor: pop and compare whenever a port presents its ack
  always @(negedge clk) begin
    if (!reset) begin
      if (a_ack) begin
        chk("a_ack_expected", 32'(qa.size() > 0), 32'd1);
        if (qa.size() > 0) begin
          mon_e = qa.pop_front();
          chk("a_rdata", 32'(a_rdata), 32'(mon_e[7:0]));
          chk("a_err", 32'(a_err), 32'(mon_e[8]));
        end
        ack_order.push_back(0);
      end
      if (b_ack) begin
        chk("b_ack_expected", 32'(qb.size() > 0), 32'd1);
        if (qb.size() > 0) begin
          mon_e = qb.pop_front();
          chk("b_rdata", 32'(b_rdata), 32'(mon_e[7:0]));
          chk("b_err", 32'(b_err), 32'(mon_e[8]));
        end
        ack_order.push_back(1);
      end
      if (c_ack) begin
        chk("c_ack_expected", 32'(qc.size() > 0), 32'd1);
        if (qc.size() > 0) begin
          mon_e = qc.pop_front();
          chk("c_rdata", 32'(c_rdata), 32'(mon_e[7:0]));
          chk("c_err", 32'(c_err), 32'(mon_e[8]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_a, cyc_b, acks;
    for (int i = 0; i < 1024; i++) begin
      m0[i] = 8'(i) ^ 8'hA5;
      m1[i] = 8'(i) ^ 8'h3C;
    end
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ports0", 32'({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata}), 32'd0);
    chk("rst_ram0", 32'({r0_rd_addr, r0_wr_addr, r0_wr_en, r0_wr_data}), 32'd0);
    chk("rst_dut1", 32'({c_ack, c_err, c_rdata, r1_rd_addr, r1_wr_en}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests right after reset: A wins the first tie
    fork
      txn(0, 1'b0, 16'h0001, 8'h00, cyc_a);
      txn(1, 1'b1, 16'h0002, 8'h77, cyc_b);
    join
    chk("tie_a_ack_cycle", 32'(cyc_a), 32'd4);
    chk("tie_b_ack_cycle", 32'(cyc_b), 32'd9);
    @(posedge clk); #1;

    txn(0, 1'b1, 16'h0123, 8'h3C, cyc_a);
    chk("wr_ack_cycle", 32'(cyc_a), 32'd4);
    chk("wr_hi_addr", 32'({tr_rd[1], tr_wr[1]}), 32'h0101);
    chk("wr_lo_addr", 32'({tr_rd[2], tr_wr[2]}), 32'h2323);
    chk("wr_en_hi_lo", 32'({tr_en[1], tr_en[2]}), 32'd0);
    chk("wr_en_xfer", 32'({tr_en[3], tr_wd[3]}), 32'h13C);
    chk("wr_en_resp", 32'(tr_en[4]), 32'd0);
    @(posedge clk); #1;
    txn(0, 1'b0, 16'h0123, 8'h00, cyc_a);
    chk("rd_ack_cycle", 32'(cyc_a), 32'd4);
    chk("rd_no_wr_en", 32'(tr_en[3]), 32'd0);
    chk("rd_data_0123", 32'({a_err, a_rdata}), 32'h03C);
    @(posedge clk); #1;

    txn(0, 1'b0, 16'h0400, 8'h00, cyc_a);
    chk("oow_ack_cycle", 32'(cyc_a), 32'd1);
    chk("oow_no_ram", 32'({tr_rd[1], tr_en[1]}), 32'd0);
    chk("oow_err_rdata", 32'({a_err, a_rdata}), 32'h1FF);
    @(posedge clk); #1;

    // Both ports hold req continuously: service must alternate
    ack_order.delete();
    fork
      rand_driver(0, 6, 0);
      rand_driver(1, 6, 0);
    join
    @(negedge clk); #1;
    chk("fair_count", 32'(ack_order.size()), 32'd12);
    for (int i = 1; i < ack_order.size(); i++)
      chk($sformatf("fair_alt_%0d", i), 32'(ack_order[i] != ack_order[i-1]), 32'd1);

    fork
      rand_driver(0, 40, 3);
      rand_driver(1, 40, 3);
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset during the XFER cycle of a write must suppress the write
    drive(0, 1'b1, 1'b1, 16'h0010, 8'h5A);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("xfer_wr_en_high", 32'(r0_wr_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_en_drop", 32'({r0_wr_en, a_ack, a_rdata}), 32'd0);
    drive(0, 1'b0, 1'b0, 16'h0010, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      acks += int'(a_ack);
    end
    chk("no_ack_after_rst", 32'(acks), 32'd0);
    txn(0, 1'b0, 16'h0010, 8'h00, cyc_a);
    chk("post_rst_rd_0010", 32'(a_rdata), 32'(m0[16]));
    @(posedge clk); #1;

    // Window starting at 16'hC000
    txn(2, 1'b0, 16'hBFFF, 8'h00, cyc_a);
    chk("c_below_ack_cycle", 32'(cyc_a), 32'd1);
    @(posedge clk); #1;
    txn(2, 1'b0, 16'hC400, 8'h00, cyc_a);
    chk("c_above_ack_cycle", 32'(cyc_a), 32'd1);
    @(posedge clk); #1;
    txn(2, 1'b0, 16'hC3FF, 8'h00, cyc_a);
    chk("c_top_ack_cycle", 32'(cyc_a), 32'd4);
    chk("c_top_addr", 32'({tr_rd[1], tr_wr[1], tr_rd[2], tr_wr[2]}), 32'hC3C3FFFF);
    chk("c_top_data", 32'({c_err, c_rdata}), 32'h0C3);

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
